// File: rtl/sdram_arbiter.sv
// Shares the sdram word port between the ST bus (primary, zero-latency pass-through)
// and a DMA port (secondary, registered fixed-latency accesses); also schedules ST refresh.
module sdram_arbiter #(
  parameter int RAM_LAT = 4,
  parameter int AW      = 22
) (
  input  logic          clk_32,
  input  logic          reset,
  input  logic          ram_ready,
  input  logic          st_cs,
  input  logic          st_we,
  input  logic [1:0]    st_ds,
  input  logic [AW:1]   st_addr,
  input  logic [15:0]   st_din,
  input  logic          st_refresh,
  output logic [15:0]   st_dout,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW:1]   dma_addr,
  input  logic [15:0]   dma_din,
  output logic          dma_ack,
  output logic [15:0]   dma_dout,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_refresh,
  output logic [1:0]    ram_ds,
  output logic [AW:1]   ram_addr,
  output logic [15:0]   ram_din,
  input  logic [15:0]   ram_dout,
  output logic          collision
);

  localparam int            CW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ST_OP, REF_OP, DMA_OP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            st_pend;
  logic            ref_pend;
  logic            ref_short;
  logic            st_cs_q;
  logic            st_ref_q;
  logic            cs_r;
  logic            we_r;
  logic [1:0]      ds_r;
  logic [AW:1]     addr_r;
  logic [15:0]     din_r;
  logic            st_path;

  // The ST bus drives the sdram directly while it owns the port, including the
  // granting IDLE cycle, so ST timing is untouched. The DMA ack cycle keeps ram_cs low.
  always_comb begin
    st_path = (state == ST_OP) ||
              ((state == IDLE) && ram_ready && st_cs && !dma_ack);
  end

  assign ram_cs      = st_path ? st_cs   : cs_r;
  assign ram_we      = st_path ? st_we   : we_r;
  assign ram_ds      = st_path ? st_ds   : ds_r;
  assign ram_addr    = st_path ? st_addr : addr_r;
  assign ram_din     = st_path ? st_din  : din_r;
  assign ram_refresh = (state == REF_OP) && (ref_short || st_refresh);

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values; reset is synchronous and only taken on the clock edge.
  always_ff @(posedge clk_32) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      st_pend   <= 1'b0;
      ref_pend  <= 1'b0;
      ref_short <= 1'b0;
      st_cs_q   <= 1'b0;
      st_ref_q  <= 1'b0;
      cs_r      <= 1'b0;
      we_r      <= 1'b0;
      ds_r      <= 2'b11;
      addr_r    <= '0;
      din_r     <= '0;
      dma_ack   <= 1'b0;
      dma_dout  <= '0;
      st_dout   <= '0;
      collision <= 1'b0;
    end else begin
      st_cs_q  <= st_cs;
      st_ref_q <= st_refresh;
      dma_ack  <= 1'b0;
      if (st_path) st_dout <= ram_dout;

      case (state)
        IDLE: begin
          if (ram_ready) begin
            if (st_cs || st_pend) begin
              state   <= ST_OP;
              st_pend <= 1'b0;
              if (st_refresh) ref_pend <= 1'b1;
            end else if (st_refresh) begin
              state     <= REF_OP;
              ref_pend  <= 1'b0;
              ref_short <= 1'b0;
            end else if (ref_pend) begin
              state     <= REF_OP;
              ref_pend  <= 1'b0;
              ref_short <= 1'b1;
            end else if (dma_req && !dma_ack) begin
              // A request still high during its own ack cycle is the old one.
              state  <= DMA_OP;
              cnt    <= '0;
              cs_r   <= 1'b1;
              we_r   <= dma_we;
              ds_r   <= 2'b00;
              addr_r <= dma_addr;
              din_r  <= dma_din;
            end
          end
        end

        ST_OP: begin
          if (st_refresh && !st_ref_q) ref_pend <= 1'b1;
          if (!st_cs) state <= IDLE;
        end

        REF_OP: begin
          if (ref_short || !st_refresh) state <= IDLE;
        end

        DMA_OP: begin
          if (st_cs && !st_cs_q) begin
            st_pend   <= 1'b1;
            collision <= 1'b1;
          end
          if (st_refresh && !st_ref_q) ref_pend <= 1'b1;
          if (cnt == CNT_LAST) begin
            dma_dout <= ram_dout;
            dma_ack  <= 1'b1;
            cs_r     <= 1'b0;
            we_r     <= 1'b0;
            ds_r     <= 2'b11;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a per-cycle vector table plus hand-written
// sequences for collision, pending refresh and mid-access reset.
module tb_sdram_arbiter;

  localparam int AW = 22;

  logic          clk_32 = 1'b0;
  logic          reset;
  logic          ram_ready;
  logic          st_cs, st_we, st_refresh;
  logic [1:0]    st_ds;
  logic [AW:1]   st_addr;
  logic [15:0]   st_din, st_dout;
  logic          dma_req, dma_we, dma_ack;
  logic [AW:1]   dma_addr;
  logic [15:0]   dma_din, dma_dout;
  logic          ram_cs, ram_we, ram_refresh, collision;
  logic [1:0]    ram_ds;
  logic [AW:1]   ram_addr;
  logic [15:0]   ram_din, ram_dout;

  sdram_arbiter #(.RAM_LAT(4), .AW(AW)) dut (
    .clk_32(clk_32), .reset(reset), .ram_ready(ram_ready),
    .st_cs(st_cs), .st_we(st_we), .st_ds(st_ds), .st_addr(st_addr),
    .st_din(st_din), .st_refresh(st_refresh), .st_dout(st_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_dout(dma_dout),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_refresh(ram_refresh), .ram_ds(ram_ds),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .collision(collision)
  );

  always #5 clk_32 = ~clk_32;

  typedef struct {
    string       name;
    logic        rdy, scs, swe;
    logic [1:0]  sds;
    logic        sref, dreq, dwe;
    logic [15:0] rdout;
    logic        ecs, ewe;
    logic [1:0]  eds;
    logic        eref, eack;
    logic        csd;
    logic [15:0] esd;
    logic        cdd;
    logic [15:0] edd;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input string name, input logic rdy, input logic scs, input logic swe,
                     input logic [1:0] sds, input logic sref, input logic dreq, input logic dwe,
                     input logic [15:0] rdout, input logic ecs, input logic ewe,
                     input logic [1:0] eds, input logic eref, input logic eack,
                     input logic csd, input logic [15:0] esd,
                     input logic cdd, input logic [15:0] edd);
    vec_t v;
    v.name = name; v.rdy = rdy; v.scs = scs; v.swe = swe; v.sds = sds; v.sref = sref;
    v.dreq = dreq; v.dwe = dwe; v.rdout = rdout; v.ecs = ecs; v.ewe = ewe; v.eds = eds;
    v.eref = eref; v.eack = eack; v.csd = csd; v.esd = esd; v.cdd = cdd; v.edd = edd;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_32);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_32);
  endtask

  task automatic apply(input vec_t v);
    tick();
    ram_ready = v.rdy; st_cs = v.scs; st_we = v.swe; st_ds = v.sds;
    st_refresh = v.sref; dma_req = v.dreq; dma_we = v.dwe; ram_dout = v.rdout;
    sample();
    check(v.name, 32'({ram_cs, ram_we, ram_ds, ram_refresh, dma_ack}),
          32'({v.ecs, v.ewe, v.eds, v.eref, v.eack}));
    if (v.csd) check({v.name, "_st_dout"}, 32'(st_dout), 32'(v.esd));
    if (v.cdd) check({v.name, "_dma_dout"}, 32'(dma_dout), 32'(v.edd));
  endtask

  initial begin
    //  name           rdy scs swe sds    sref dreq dwe rdout     cs we ds    ref ack csd esd       cdd edd
    add("st_rd_start", 1, 1, 0, 2'b00, 0, 0, 0, 16'hBEEF, 1, 0, 2'b00, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_rd_hold",  1, 1, 0, 2'b00, 0, 0, 0, 16'hBEEF, 1, 0, 2'b00, 0, 0, 1, 16'hBEEF, 0, 16'h0);
    add("st_rd_end",   1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("idle_a",      1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_wr",       1, 1, 1, 2'b10, 0, 0, 0, 16'h0,    1, 1, 2'b10, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_wr_end",   1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("dwr_req",     1, 0, 0, 2'b11, 0, 1, 1, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    for (int i = 1; i <= 4; i++)
      add($sformatf("dwr_c%0d", i), 1, 0, 0, 2'b11, 0, 1, 1, 16'h0, 1, 1, 2'b00, 0, 0, 0, 16'h0, 0, 16'h0);
    add("dwr_ack",     1, 0, 0, 2'b11, 0, 1, 1, 16'h0,    0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 16'h0);
    add("dwr_gap",     1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("drd_req",     1, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    for (int i = 1; i <= 3; i++)
      add($sformatf("drd_c%0d", i), 1, 0, 0, 2'b11, 0, 1, 0, 16'h0, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0, 16'h0);
    add("drd_c4",      1, 0, 0, 2'b11, 0, 1, 0, 16'hCAFE, 1, 0, 2'b00, 0, 0, 0, 16'h0,    0, 16'h0);
    add("drd_ack",     1, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 1, 0, 16'h0,    1, 16'hCAFE);
    add("drd_rereq",   1, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    1, 16'hCAFE);
    for (int i = 1; i <= 4; i++)
      add($sformatf("drd2_c%0d", i), 1, 0, 0, 2'b11, 0, 1, 0, 16'h0, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0, 16'h0);
    add("drd2_ack",    1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 1, 0, 16'h0,    1, 16'h0000);
    add("idle_b",      1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("ref_dma_req", 1, 0, 0, 2'b11, 1, 1, 1, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("ref_on1",     1, 0, 0, 2'b11, 1, 1, 1, 16'h0,    0, 0, 2'b11, 1, 0, 0, 16'h0,    0, 16'h0);
    add("ref_on2",     1, 0, 0, 2'b11, 1, 1, 1, 16'h0,    0, 0, 2'b11, 1, 0, 0, 16'h0,    0, 16'h0);
    add("ref_fall",    1, 0, 0, 2'b11, 0, 1, 1, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("ref_idle",    1, 0, 0, 2'b11, 0, 1, 1, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    for (int i = 1; i <= 4; i++)
      add($sformatf("dref_c%0d", i), 1, 0, 0, 2'b11, 0, 1, 1, 16'h0, 1, 1, 2'b00, 0, 0, 0, 16'h0, 0, 16'h0);
    add("dref_ack",    1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 16'h0);
    add("idle_c",      1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_ref_both", 1, 1, 0, 2'b00, 1, 0, 0, 16'h0,    1, 0, 2'b00, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_ref_hold", 1, 1, 0, 2'b00, 1, 0, 0, 16'h0,    1, 0, 2'b00, 0, 0, 0, 16'h0,    0, 16'h0);
    add("st_ref_end",  1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("pref_idle",   1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("pref_pulse",  1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 1, 0, 0, 16'h0,    0, 16'h0);
    add("pref_done",   1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("nrdy_1",      0, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("nrdy_ref",    0, 0, 0, 2'b11, 1, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("nrdy_3",      0, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    add("rdy_up",      1, 0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);
    for (int i = 1; i <= 4; i++)
      add($sformatf("rdy_dma_c%0d", i), 1, 0, 0, 2'b11, 0, 1, 0, 16'h0, 1, 0, 2'b00, 0, 0, 0, 16'h0, 0, 16'h0);
    add("rdy_dma_ack", 1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 1, 0, 16'h0,    0, 16'h0);
    add("rdy_no_ref",  1, 0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 0, 2'b11, 0, 0, 0, 16'h0,    0, 16'h0);

    reset = 1'b1; ram_ready = 1'b1; st_cs = 1'b0; st_we = 1'b0; st_ds = 2'b11;
    st_addr = 22'h001234; st_din = 16'h1111; st_refresh = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 22'h3FFFFF; dma_din = 16'h55AA;
    ram_dout = 16'h0;
    repeat (2) @(posedge clk_32);
    #1 reset = 1'b0;
    sample();
    check("rst_ram_strobes", 32'({ram_cs, ram_we, ram_refresh}), 32'h0);
    check("rst_ram_ds", 32'(ram_ds), 32'h3);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_din", 32'(ram_din), 32'h0);
    check("rst_dma", 32'({dma_ack, dma_dout}), 32'h0);
    check("rst_st_dout", 32'(st_dout), 32'h0);
    check("rst_collision", 32'(collision), 32'h0);

    foreach (vecs[i]) apply(vecs[i]);

    // st_cs arrives mid-DMA: DMA finishes, ST follows the ack, then a
    // refresh raised during ST_OP is served later as a one-cycle pulse.
    tick(); dma_req = 1'b1; dma_we = 1'b1; sample();
    check("col_c0_cs", 32'(ram_cs), 32'h0);
    tick(); sample();
    check("col_c1_cs", 32'(ram_cs), 32'h1);
    tick(); st_cs = 1'b1; st_we = 1'b0; st_ds = 2'b00; sample();
    check("col_c2_dma_fields", 32'({ram_cs, ram_we, ram_ds}), 32'({1'b1, 1'b1, 2'b00}));
    check("col_c2_addr", 32'(ram_addr), 32'h3FFFFF);
    check("col_c2_din", 32'(ram_din), 32'h55AA);
    check("col_c2_collision", 32'(collision), 32'h0);
    tick(); sample();
    check("col_c3_collision", 32'(collision), 32'h1);
    tick(); sample();
    check("col_c4_cs", 32'({ram_cs, dma_ack}), 32'h2);
    tick(); dma_req = 1'b0; sample();
    check("col_c5_ack", 32'({ram_cs, dma_ack}), 32'h1);
    tick(); st_refresh = 1'b1; sample();
    check("col_c6_st_op", 32'({ram_cs, ram_we, ram_refresh}), 32'h4);
    check("col_c6_addr", 32'(ram_addr), 32'h001234);
    check("col_c6_din", 32'(ram_din), 32'h1111);
    tick(); st_cs = 1'b0; st_ds = 2'b11; st_refresh = 1'b0; sample();
    check("col_c7_end", 32'({ram_cs, ram_refresh}), 32'h0);
    tick(); sample();
    check("col_c8_ref", 32'(ram_refresh), 32'h0);
    tick(); sample();
    check("col_c9_ref_pulse", 32'(ram_refresh), 32'h1);
    tick(); sample();
    check("col_c10_ref", 32'(ram_refresh), 32'h0);
    check("col_sticky", 32'(collision), 32'h1);

    // Reset in the middle of a DMA access drops it without an ack.
    tick(); dma_req = 1'b1; dma_we = 1'b0; sample();
    tick(); sample();
    check("rstdma_c1_cs", 32'(ram_cs), 32'h1);
    tick(); reset = 1'b1; sample();
    check("rstdma_c2_cs", 32'(ram_cs), 32'h1);
    tick(); reset = 1'b0; dma_req = 1'b0; sample();
    check("rstdma_c3", 32'({ram_cs, dma_ack, collision}), 32'h0);
    check("rstdma_c3_ds", 32'(ram_ds), 32'h3);
    for (int i = 4; i <= 7; i++) begin
      tick(); sample();
      check($sformatf("rstdma_c%0d_no_ack", i), 32'({ram_cs, dma_ack}), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
